// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared state encoding and constants for the data SRAM responder
package data_sram_resp_pkg;
  typedef enum logic {INIT, READY} state_e;
  localparam int DEFAULT_DEPTH_LOG2 = 12;
  localparam logic [31:0] MISS_RDATA = 32'h0;
endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: synchronous word RAM with 4 byte-lane write enables and one read-first port
module data_ram_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: zero-initialised word SRAM with byte writes, region check and access counters
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req,
  output logic        addr_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] init_ptr_q, init_ptr_d;
  logic [31:0]           rdata_q, rdata_d, rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic                  src_q, src_d, addr_err_q, addr_err_d;
  logic                  acc, hit, ram_en;
  logic [3:0]            ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_wdata, ram_rdata;
  logic                  unused_addr;
  assign unused_addr = ^data_sram_addr[1:0];
  // src_q selects the RAM port output for hits; otherwise rdata_q carries reset/miss values
  always_comb begin
    acc        = (state_q == READY) && data_sram_en;
    hit        = data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
    state_d    = ((state_q == INIT) && (&init_ptr_q)) ? READY : state_q;
    init_ptr_d = (state_q == INIT) ? init_ptr_q + 1'b1 : init_ptr_q;
    src_d      = acc ? hit : src_q;
    rdata_d    = (acc && !hit) ? MISS_RDATA : rdata_q;
    addr_err_d = acc && !hit;
    rd_count_d = (acc && hit && data_sram_wen == 4'h0) ? rd_count_q + 32'd1 : rd_count_q;
    wr_count_d = (acc && hit && data_sram_wen != 4'h0) ? wr_count_q + 32'd1 : wr_count_q;
    ram_en     = (state_q == INIT) || (acc && hit);
    ram_we     = (state_q == INIT) ? 4'hF : data_sram_wen;
    ram_addr   = (state_q == INIT) ? init_ptr_q : data_sram_addr[DEPTH_LOG2+1:2];
    ram_wdata  = (state_q == INIT) ? 32'h0 : data_sram_wdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      rdata_q    <= 32'h0;
      src_q      <= 1'b0;
      addr_err_q <= 1'b0;
      rd_count_q <= 32'h0;
      wr_count_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rdata_q    <= rdata_d;
      src_q      <= src_d;
      addr_err_q <= addr_err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end
  data_ram_array #(.AW(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
  assign data_sram_rdata = src_q ? ram_rdata : rdata_q;
  assign stall_req       = state_q == INIT;
  assign addr_err        = addr_err_q;
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed scoreboard bench for data_sram_resp with DEPTH_LOG2=4, BASE_ADDR=0
module tb_data_sram_resp;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rd;
    logic [31:0] wr;
    logic        stall;
  } exp_t;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata, rd_count, wr_count;
  logic        stall_req, addr_err;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata, m_rd, m_wr;
  int          init_left;
  always #5 clk = ~clk;
  data_sram_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall_req       (stall_req),
    .addr_err        (addr_err),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic settle(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".rdata"}, data_sram_rdata, e.rdata);
    chk({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, e.err});
    chk({tag, ".rd_count"}, rd_count, e.rd);
    chk({tag, ".wr_count"}, wr_count, e.wr);
    chk({tag, ".stall_req"}, {31'b0, stall_req}, {31'b0, e.stall});
  endtask
  task automatic do_reset();
    exp_t e;
    resetn = 1'b0;
    data_sram_en = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_rdata = 32'h0; m_rd = 32'h0; m_wr = 32'h0; init_left = 16;
    e.rdata = 32'h0; e.err = 1'b0; e.rd = 32'h0; e.wr = 32'h0; e.stall = 1'b1;
    q.push_back(e);
    settle("reset");
    resetn = 1'b1;
  endtask
  task automatic cyc(input string tag, input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int idx;
    data_sram_en = en; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    e.err = 1'b0;
    if (init_left > 0) init_left--;
    else if (en) begin
      idx = int'(addr[5:2]);
      if (addr[31:6] != 26'h0) begin
        m_rdata = 32'h0;
        e.err = 1'b1;
      end else begin
        m_rdata = m_mem[idx];
        if (wen == 4'h0) m_rd = m_rd + 32'd1;
        else begin
          m_wr = m_wr + 32'd1;
          for (int b = 0; b < 4; b++) if (wen[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    e.rdata = m_rdata; e.rd = m_rd; e.wr = m_wr; e.stall = init_left > 0;
    q.push_back(e);
    settle(tag);
    data_sram_en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    cyc("init_wr", 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
    cyc("init_miss", 1'b1, 4'h0, 32'h40, 32'h0);
    for (int i = 0; i < 14; i++) cyc("init_idle", 1'b0, 4'h0, 32'h0, 32'h0);
    cyc("rd_0x20", 1'b1, 4'h0, 32'h20, 32'h0);
    cyc("hold", 1'b0, 4'h0, 32'h0, 32'h0);
    chk("init_read_zero", data_sram_rdata, 32'h0);
    cyc("byte_full", 1'b1, 4'hF, 32'h10, 32'hAABB_CCDD);
    cyc("byte_lane1", 1'b1, 4'b0010, 32'h10, 32'h0000_5500);
    cyc("byte_rd", 1'b1, 4'h0, 32'h10, 32'h0);
    chk("byte_merge", data_sram_rdata, 32'hAABB_55DD);
    cyc("rf_wr", 1'b1, 4'hF, 32'h8, 32'h1234_5678);
    chk("read_first_old", data_sram_rdata, 32'h0);
    cyc("rf_rd", 1'b1, 4'h0, 32'h8, 32'h0);
    chk("read_after_write", data_sram_rdata, 32'h1234_5678);
    cyc("miss", 1'b1, 4'h0, 32'h40, 32'h0);
    chk("miss_err", {31'b0, addr_err}, 32'h1);
    cyc("miss_after", 1'b0, 4'h0, 32'h0, 32'h0);
    cyc("miss_wr", 1'b1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF);
    cyc("b2b_w0", 1'b1, 4'hF, 32'h4, 32'h1111_1111);
    cyc("b2b_r0", 1'b1, 4'h0, 32'h4, 32'h0);
    cyc("b2b_w1", 1'b1, 4'b1100, 32'h3C, 32'hCAFE_0000);
    cyc("b2b_r1", 1'b1, 4'h0, 32'h3F, 32'h0);
    cyc("b2b_r2", 1'b1, 4'h0, 32'h12, 32'h0);
    cyc("b2b_idle", 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc("reinit", 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) cyc("zero_rd", 1'b1, 4'h0, 32'(i * 4), 32'h0);
    cyc("final_idle", 1'b0, 4'h0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12, giving a memory of 2^DEPTH_LOG2 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte base of the region, aligned to 4*2^DEPTH_LOG2.
REQ-003 Port clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 Port resetn  input  1  synchronous, active-low reset.
REQ-005 Port data_sram_en  input  1  access request this cycle.
REQ-006 Port data_sram_wen  input  4  byte-lane write enables; bit i covers bits [8i+7:8i]; 0 means read.
REQ-007 Port data_sram_addr  input  32  byte address; bits [1:0] are ignored.
REQ-008 Port data_sram_wdata  input  32  store data, already lane-aligned.
REQ-009 Port data_sram_rdata  output  32  registered read data.
REQ-010 Port stall_req  output  1  the block is busy initialising; the requester holds off.
REQ-011 Port addr_err  output  1  one-cycle pulse, aligned with data_sram_rdata, for a request outside the region.
REQ-012 Port rd_count  output  32  number of accepted reads.
REQ-013 Port wr_count  output  32  number of accepted writes.

Function
REQ-014 The FSM SHALL have two states: INIT and READY.
REQ-015 INIT behaviour:
- Each cycle, write 32'h0 to word init_ptr, then increment init_ptr.
- stall_req = 1.
- All requests are ignored: no write, no count, no addr_err.
REQ-016 INIT SHALL move to READY on the cycle after word 2^DEPTH_LOG2-1 is written, so INIT lasts exactly 2^DEPTH_LOG2 cycles; stall_req = 0 in READY.
REQ-017 Hit: data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]. Word index: data_sram_addr[DEPTH_LOG2+1:2].
REQ-018 READY, en=1, hit, wen!=0:
- Write only the enabled lanes of data_sram_wdata at the rising edge.
- Increment wr_count.
- data_sram_rdata takes the pre-write word (read-first).
REQ-019 READY, en=1, hit, wen=0:
- data_sram_rdata = mem[index] one cycle later (latency 1).
- Increment rd_count.
REQ-020 READY, en=1, miss:
- No write and no count change.
- data_sram_rdata = 32'h0 next cycle.
- addr_err = 1 for that one cycle.
REQ-021 When en=0, data_sram_rdata SHALL hold its value and addr_err SHALL be 0.
REQ-022 A read issued the cycle after a write to the same word SHALL return the merged new word.
REQ-023 Both counters SHALL wrap from 32'hFFFF_FFFF to 0 without saturating.
REQ-024 Back-to-back requests SHALL be accepted every cycle in READY, with no bubbles.

Reset
REQ-025 While resetn=0 at a clock edge, the block SHALL load:
- state = INIT, init_ptr = 0.
- data_sram_rdata = 0, addr_err = 0.
- rd_count = 0, wr_count = 0.
REQ-026 stall_req SHALL be 1 in the first cycle after resetn rises.
REQ-027 Reset asserted mid-INIT or mid-READY SHALL restart initialisation from word 0; array contents need not be preserved.

Structure
REQ-028 A shared package SHALL hold:
- the state encoding (INIT, READY);
- the default DEPTH_LOG2;
- the miss read value 32'h0.
REQ-029 The storage SHALL be one sub-module, data_ram_array, providing a synchronous 4-lane byte-write RAM with one read-first port. Address decode, FSM, counters and error logic stay in data_sram_resp.

Verification
REQ-030 Init, DEPTH_LOG2=4: release resetn -> stall_req=1 for exactly 16 cycles, then 0; a read of 0x0000_0020 returns 32'h0.
REQ-031 Byte store: write 32'hAABBCCDD with wen=4'b1111 to 0x10, then wen=4'b0010 with wdata 32'h0000_5500, then read 0x10 -> rdata 32'hAABB55DD one cycle after the read.
REQ-032 Read-first: write 32'h1234_5678 to 0x8 (prior content 0) -> rdata 32'h0 next cycle; immediate read of 0x8 -> 32'h1234_5678.
REQ-033 Miss: with BASE_ADDR=0 and DEPTH_LOG2=4, read 0x0000_0040 -> addr_err=1 for one cycle, rdata=0, rd_count unchanged.
REQ-034 Counters and stall: 3 reads plus 2 writes back-to-back -> rd_count=3, wr_count=2; a request issued during INIT -> no count change and no array change.
REQ-035 Mid-operation reset: pull resetn low for one cycle while in READY -> counters 0, stall_req=1 for 2^DEPTH_LOG2 cycles, memory reads back zero afterwards.
